decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction/data width (>=32).
REQ-002 SHALL have parameter AWIDTH, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries (power of 2, >=2).
REQ-004 SHALL have one clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst input 1 asynchronous active-low reset.
REQ-005 SHALL have ports:
- in_valid_i input 1: upstream has an instruction
- in_ready_o output 1: block can accept
- pc_i input AWIDTH: PC of the instruction
- insn_i input DWIDTH: instruction word
- flush_i input 1: synchronous discard of all buffered entries
- out_valid_o output 1: head entry valid
- out_ready_i input 1: downstream accepts head
- pc_o input-copy output AWIDTH; insn_o output DWIDTH
- opcode_o output 7; rd_o, rs1_o, rs2_o output 5 each
- funct3_o output 3; funct7_o output 7; shamt_o output 5
- imm_o output DWIDTH: sign-extended immediate
- illegal_o output 1: entry failed decode
- count_o output $clog2(DEPTH)+1: occupied entries

Function
REQ-006 SHALL decode insn_i combinationally at the input and write the full decoded record into a DEPTH-entry FIFO on push (in_valid_i & in_ready_o).
REQ-007 SHALL drive all out fields from the FIFO head; pop on out_valid_o & out_ready_i.
REQ-008 SHALL assert in_ready_o = (count_o < DEPTH) & ~flush_i; out_valid_o = (count_o != 0).
REQ-009 SHALL give latency 1: push at edge N -> out_valid_o high after edge N when buffer was empty.
REQ-010 SHALL, on simultaneous push and pop, keep count_o unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-011 SHALL, on flush_i, clear count_o and pointers at the next edge; a pop in the same cycle is ignored; no push occurs.
REQ-012 SHALL keep head fields stable while out_valid_o & ~out_ready_i.
REQ-013 SHALL decode opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, JALR 1100111, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111.
REQ-014 SHALL extract rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25] only where the format uses them; unused fields SHALL be 0.
REQ-015 SHALL, for OP-IMM funct3 001/101, output shamt_o=[24:20] and funct7_o=[31:25]; shamt_o=0 for all other instructions.
REQ-016 SHALL produce imm_o: I [31:20], S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, U {[31:12],12'b0}, J {[31],[19:12],[20],[30:21],0}, sign-extended to DWIDTH; R-type 0.
REQ-017 SHALL set illegal_o for: unknown opcode; insn[1:0]!=11; JALR funct3!=000; BRANCH funct3 010/011; LOAD funct3 011/110/111; STORE funct3 >=011; R funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM shift with funct7 not 0000000 (001) or not 0000000/0100000 (101).
REQ-018 SHALL, for illegal entries, pass pc_o, insn_o, opcode_o and zero all other decoded fields including imm_o.

Reset
REQ-019 SHALL, while rst=0, force count_o=0, pointers=0, out_valid_o=0, all out fields 0; in_ready_o=1 after release.
REQ-020 SHALL discard buffered entries if rst asserts mid-operation; no partial entry survives.

Verification
REQ-021 ADDI x1,x2,-5 (0xFFB10093) pc 0x100 -> next cycle out_valid=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFB, illegal=0.
REQ-022 SRAI x3,x4,7 (0x40725193) -> funct7=0x20, shamt=7, funct3=5, rs2=0.
REQ-023 out_ready=0, push 3 with DEPTH=2 -> in_ready=0 after 2, count=2; then out_ready=1 -> order preserved, 3rd accepted.
REQ-024 BEQ offset -4 (0xFE000EE3) -> imm=0xFFFFFFFC, rd=0; JALR with funct3=001 -> illegal=1, imm=0.
REQ-025 count=2, flush_i=1 with in_valid=1 -> next cycle count=0, out_valid=0, flushed input not stored.
REQ-026 rst low mid-stream with count=1 -> out_valid=0 immediately (async), count=0.

Source files
------------

// File: rtl/decode_pipe.sv
// RV32 instruction decoder feeding a small FIFO of fully decoded records.
// Output fields come from the FIFO head and read as zero whenever it is empty.
module decode_pipe #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [AWIDTH-1:0]          pc_i,
  input  logic [DWIDTH-1:0]          insn_i,
  input  logic                       flush_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [AWIDTH-1:0]          pc_o,
  output logic [DWIDTH-1:0]          insn_o,
  output logic [6:0]                 opcode_o,
  output logic [4:0]                 rd_o,
  output logic [4:0]                 rs1_o,
  output logic [4:0]                 rs2_o,
  output logic [2:0]                 funct3_o,
  output logic [6:0]                 funct7_o,
  output logic [4:0]                 shamt_o,
  output logic [DWIDTH-1:0]          imm_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] imm;
    logic              illegal;
  } rec_t;

  rec_t              dec;
  rec_t              head;
  rec_t              mem [DEPTH];
  logic              bad;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [DWIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop;

  assign f3    = insn_i[14:12];
  assign f7    = insn_i[31:25];
  assign imm_i = DWIDTH'($signed(insn_i[31:20]));
  assign imm_s = DWIDTH'($signed({insn_i[31:25], insn_i[11:7]}));
  assign imm_b = DWIDTH'($signed({insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0}));
  assign imm_u = DWIDTH'($signed({insn_i[31:12], 12'b0}));
  assign imm_j = DWIDTH'($signed({insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0}));

  always_comb begin
    dec        = '0;
    bad        = 1'b0;
    dec.pc     = pc_i;
    dec.insn   = insn_i;
    dec.opcode = insn_i[6:0];
    case (insn_i[6:0])
      OP_R: begin
        dec.rd     = insn_i[11:7];
        dec.funct3 = f3;
        dec.rs1    = insn_i[19:15];
        dec.rs2    = insn_i[24:20];
        dec.funct7 = f7;
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OP_IMM: begin
        dec.rd     = insn_i[11:7];
        dec.funct3 = f3;
        dec.rs1    = insn_i[19:15];
        dec.imm    = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.shamt  = insn_i[24:20];
          dec.funct7 = f7;
          bad = (f3 == 3'b001) ? (f7 != 7'h00) : ((f7 != 7'h00) && (f7 != 7'h20));
        end
      end
      OP_LOAD, OP_JALR: begin
        dec.rd     = insn_i[11:7];
        dec.funct3 = f3;
        dec.rs1    = insn_i[19:15];
        dec.imm    = imm_i;
        if (insn_i[6:0] == OP_JALR) bad = (f3 != 3'b000);
        else                        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE, OP_BRANCH: begin
        dec.funct3 = f3;
        dec.rs1    = insn_i[19:15];
        dec.rs2    = insn_i[24:20];
        if (insn_i[6:0] == OP_STORE) begin
          dec.imm = imm_s;
          bad     = (f3 >= 3'b011);
        end else begin
          dec.imm = imm_b;
          bad     = (f3 == 3'b010) || (f3 == 3'b011);
        end
      end
      OP_LUI, OP_AUIPC: begin
        dec.rd  = insn_i[11:7];
        dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.rd  = insn_i[11:7];
        dec.imm = imm_j;
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries keep only pc/insn/opcode so downstream sees no stale fields.
    if (bad || (insn_i[1:0] != 2'b11)) begin
      dec         = '0;
      dec.pc      = pc_i;
      dec.insn    = insn_i;
      dec.opcode  = insn_i[6:0];
      dec.illegal = 1'b1;
    end
  end

  assign in_ready_o  = (count < CW'(DEPTH)) & ~flush_i;
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Gating by occupancy makes reset and flush clear every field without clearing storage.
  assign head = out_valid_o ? mem[rd_ptr] : '0;

  assign pc_o      = head.pc;
  assign insn_o    = head.insn;
  assign opcode_o  = head.opcode;
  assign rd_o      = head.rd;
  assign rs1_o     = head.rs1;
  assign rs2_o     = head.rs2;
  assign funct3_o  = head.funct3;
  assign funct7_o  = head.funct7;
  assign shamt_o   = head.shamt;
  assign imm_o     = head.imm;
  assign illegal_o = head.illegal;
  assign count_o   = count;

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe: stimulus queues hand-computed records,
// a negedge monitor pops and compares every accepted head entry.
module tb_decode_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
  logic [31:0] pc_i, insn_i, pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
  logic [2:0]  funct3_o;
  logic        illegal_o;
  logic [1:0]  count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [4:0]  sh;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t vec [15];
  int   vectors = 0;
  int   miscompares = 0;

  decode_pipe #(.DWIDTH(32), .AWIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .insn_i(insn_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .imm_o(imm_o), .illegal_o(illegal_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] pc, insn, input logic [6:0] op,
                              input logic [4:0] rd, input logic [2:0] f3,
                              input logic [4:0] rs1, rs2, input logic [6:0] f7,
                              input logic [4:0] sh, input logic [31:0] imm, input logic ill);
    exp_t e;
    e.pc = pc; e.insn = insn; e.op = op; e.rd = rd; e.f3 = f3; e.rs1 = rs1;
    e.rs2 = rs2; e.f7 = f7; e.sh = sh; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input exp_t e);
    int unsigned waited = 0;
    @(negedge clk);
    in_valid_i = 1'b1;
    pc_i       = e.pc;
    insn_i     = e.insn;
    while (!in_ready_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_o) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready stuck low for insn %h", e.insn);
    end else begin
      @(posedge clk);
      q.push_back(e);
    end
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    @(posedge clk); #1;
    chk("drain_count", 32'(count_o), 0);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    #2;
    if (out_valid_o && out_ready_i) begin
      vectors++;
      a = mk(pc_o, insn_o, opcode_o, rd_o, funct3_o, rs1_o, rs2_o, funct7_o, shamt_o, imm_o, illegal_o);
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: insn %h with empty scoreboard", insn_o);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL record insn=%h: got pc=%h op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h sh=%0d imm=%h ill=%b expected pc=%h op=%h rd=%0d f3=%0d rs1=%0d rs2=%0d f7=%h sh=%0d imm=%h ill=%b",
                   e.insn, a.pc, a.op, a.rd, a.f3, a.rs1, a.rs2, a.f7, a.sh, a.imm, a.ill,
                   e.pc, e.op, e.rd, e.f3, e.rs1, e.rs2, e.f7, e.sh, e.imm, e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //               pc        insn          op     rd  f3  rs1 rs2 f7     sh  imm           ill
    vec[0]  = mk(32'h100, 32'hFFB10093, 7'h13, 1,  0,  2,  0,  7'h00, 0,  32'hFFFFFFFB, 0); // addi
    vec[1]  = mk(32'h104, 32'h40725193, 7'h13, 3,  5,  4,  0,  7'h20, 7,  32'h00000407, 0); // srai
    vec[2]  = mk(32'h108, 32'hFE000EE3, 7'h63, 0,  0,  0,  0,  7'h00, 0,  32'hFFFFFFFC, 0); // beq -4
    vec[3]  = mk(32'h10C, 32'h000090E7, 7'h67, 0,  0,  0,  0,  7'h00, 0,  32'h0,        1); // jalr f3=1
    vec[4]  = mk(32'h110, 32'h007302B3, 7'h33, 5,  0,  6,  7,  7'h00, 0,  32'h0,        0); // add
    vec[5]  = mk(32'h114, 32'h407302B3, 7'h33, 5,  0,  6,  7,  7'h20, 0,  32'h0,        0); // sub
    vec[6]  = mk(32'h118, 32'h12345537, 7'h37, 10, 0,  0,  0,  7'h00, 0,  32'h12345000, 0); // lui
    vec[7]  = mk(32'h11C, 32'hFE812C23, 7'h23, 0,  2,  2,  8,  7'h00, 0,  32'hFFFFFFF8, 0); // sw -8
    vec[8]  = mk(32'h120, 32'h001000EF, 7'h6F, 1,  0,  0,  0,  7'h00, 0,  32'h00000800, 0); // jal
    vec[9]  = mk(32'h124, 32'hFFFFF197, 7'h17, 3,  0,  0,  0,  7'h00, 0,  32'hFFFFF000, 0); // auipc
    vec[10] = mk(32'h128, 32'h00C2A203, 7'h03, 4,  2,  5,  0,  7'h00, 0,  32'h0000000C, 0); // lw
    vec[11] = mk(32'h12C, 32'h407312B3, 7'h33, 0,  0,  0,  0,  7'h00, 0,  32'h0,        1); // R f7=20 f3=1
    vec[12] = mk(32'h130, 32'h00C2B203, 7'h03, 0,  0,  0,  0,  7'h00, 0,  32'h0,        1); // load f3=3
    vec[13] = mk(32'h134, 32'h40309093, 7'h13, 0,  0,  0,  0,  7'h00, 0,  32'h0,        1); // slli f7=20
    vec[14] = mk(32'h138, 32'h00000001, 7'h01, 0,  0,  0,  0,  7'h00, 0,  32'h0,        1); // bits[1:0]=01

    rst = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    pc_i = '0; insn_i = '0;
    #12;
    chk("reset_count", 32'(count_o), 0);
    chk("reset_out_valid", 32'(out_valid_o), 0);
    chk("reset_insn", insn_o, 0);
    chk("reset_imm", imm_o, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_after_reset", 32'(in_ready_o), 1);

    // single-cycle latency into an empty buffer
    push(vec[0]);
    chk("latency_valid", 32'(out_valid_o), 1);
    chk("latency_count", 32'(count_o), 1);
    out_ready_i = 1'b1;
    drain();

    // back-to-back stream: push and pop every cycle keeps count at 1
    foreach (vec[i]) begin
      if (i == 1 || i == 2 || i == 3 || i == 11 || i == 13 || i == 14) begin
        push(vec[i]);
        chk("stream_count", 32'(count_o), 1);
      end
    end
    drain();

    // backpressure: buffer fills at 2, head holds, third enters after a pop
    @(negedge clk);
    out_ready_i = 1'b0;
    push(vec[4]);
    push(vec[5]);
    chk("full_count", 32'(count_o), 2);
    chk("full_ready", 32'(in_ready_o), 0);
    fork
      push(vec[6]);
      begin
        repeat (2) begin
          @(negedge clk); #1;
          chk("stall_head_insn", insn_o, 32'h007302B3);
          chk("stall_head_rs2", 32'(rs2_o), 7);
          chk("stall_ready", 32'(in_ready_o), 0);
        end
        out_ready_i = 1'b1;
      end
    join
    drain();

    // flush with a concurrent input: everything discarded, input not stored
    @(negedge clk);
    out_ready_i = 1'b0;
    push(vec[7]);
    push(vec[8]);
    chk("pre_flush_count", 32'(count_o), 2);
    @(negedge clk);
    in_valid_i = 1'b1; pc_i = vec[9].pc; insn_i = vec[9].insn; flush_i = 1'b1;
    #1 chk("flush_ready", 32'(in_ready_o), 0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    q.delete();
    chk("flush_count", 32'(count_o), 0);
    chk("flush_valid", 32'(out_valid_o), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_flush_valid", 32'(out_valid_o), 0);
    end
    out_ready_i = 1'b1;
    push(vec[7]);
    push(vec[8]);
    push(vec[9]);
    drain();

    // asynchronous reset mid-stream
    @(negedge clk);
    out_ready_i = 1'b0;
    push(vec[10]);
    chk("pre_reset_count", 32'(count_o), 1);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid_o), 0);
    chk("async_reset_count", 32'(count_o), 0);
    chk("async_reset_imm", imm_o, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready_i = 1'b1;
    push(vec[10]);
    push(vec[12]);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
